// File: rtl/mult_share_arb_if.sv
// Bundle between the requesters/consumer/multiplier side and the shared-multiplier arbiter.
// The arbiter uses the slave modport; the environment (PEs, consumer, mult_booth) uses master.
interface mult_share_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic [15:0]           mul_a;
  logic [15:0]           mul_b;
  logic [31:0]           mul_p;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_p;

  modport slave (
    input  req_valid, req_a, req_b, mul_p, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p
  );

  modport master (
    output req_valid, req_a, req_b, mul_p, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p
  );
endinterface

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one combinational multiplier: operand reg -> mult_booth -> product reg.
// Optional MULT_ARB_STALL_CNT_EN adds a saturating stall_cnt output.
module mult_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  mult_share_arb_if.slave  bus
`ifdef MULT_ARB_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W-1:0] ONE_ID    = ID_W'(1'b1);

  logic                s1_v_r;
  logic [15:0]         s1_a_r;
  logic [15:0]         s1_b_r;
  logic [ID_W-1:0]     s1_id_r;
  logic [ID_W-1:0]     rr_ptr_r;
  logic                rsp_valid_r;
  logic [ID_W-1:0]     rsp_id_r;
  logic [31:0]         rsp_p_r;

  logic [NUM_REQ-1:0]  grant_s;
  logic [ID_W-1:0]     grant_id_s;
  logic                found_s;
  logic [ID_W:0]       sum_s;
  logic [ID_W:0]       diff_s;
  logic [ID_W-1:0]     cand_s;
  logic                hit_s;
  logic                adv1_s;
  logic                adv2_s;
  logic [NUM_REQ-1:0]  req_ready_s;
  logic                hs_s;
  logic [15:0]         sel_a_s;
  logic [15:0]         sel_b_s;
  logic [ID_W-1:0]     next_ptr_s;

  assign adv2_s = !rsp_valid_r | bus.rsp_ready;
  assign adv1_s = !s1_v_r | adv2_s;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping mod NUM_REQ.
  always_comb begin
    grant_s    = '0;
    grant_id_s = '0;
    found_s    = 1'b0;
    sum_s      = '0;
    diff_s     = '0;
    cand_s     = '0;
    hit_s      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s              = {1'b0, rr_ptr_r} + k[ID_W:0];
      diff_s             = sum_s - NUM_REQ_W;
      cand_s             = (sum_s >= NUM_REQ_W) ? diff_s[ID_W-1:0] : sum_s[ID_W-1:0];
      hit_s              = !found_s && bus.req_valid[cand_s];
      grant_s[cand_s]    = grant_s[cand_s] | hit_s;
      grant_id_s         = hit_s ? cand_s : grant_id_s;
      found_s            = found_s | hit_s;
    end
  end

  // Accept only when S1 can take a new operand pair; nothing is accepted while reset is held.
  always_comb begin
    req_ready_s = '0;
    if (rst) begin
      req_ready_s = '0;
    end else begin
      req_ready_s = grant_s & {NUM_REQ{adv1_s}};
    end
  end

  assign hs_s       = |req_ready_s;
  assign sel_a_s    = bus.req_a[{grant_id_s, 4'h0} +: 16];
  assign sel_b_s    = bus.req_b[{grant_id_s, 4'h0} +: 16];
  assign next_ptr_s = (grant_id_s == LAST_ID) ? '0 : (grant_id_s + ONE_ID);

  // Stage 1: operand register feeding the multiplier, plus round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_r   <= 1'b0;
      s1_a_r   <= 16'h0000;
      s1_b_r   <= 16'h0000;
      s1_id_r  <= '0;
      rr_ptr_r <= '0;
    end else if (hs_s) begin
      s1_v_r   <= 1'b1;
      s1_a_r   <= sel_a_s;
      s1_b_r   <= sel_b_s;
      s1_id_r  <= grant_id_s;
      rr_ptr_r <= next_ptr_s;
    end else if (adv1_s) begin
      s1_v_r   <= 1'b0;
    end else begin
      s1_v_r   <= s1_v_r;
    end
  end

  // Stage 2: registered product/tag; held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_p_r     <= 32'h0000_0000;
    end else if (adv2_s) begin
      rsp_valid_r <= s1_v_r;
      if (s1_v_r) begin
        rsp_p_r  <= bus.mul_p;
        rsp_id_r <= s1_id_r;
      end else begin
        rsp_p_r  <= rsp_p_r;
        rsp_id_r <= rsp_id_r;
      end
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.mul_a     = s1_a_r;
  assign bus.mul_b     = s1_b_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_p     = rsp_p_r;

`ifdef MULT_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_r;
  logic        stall_s;

  assign stall_s = (|bus.req_valid) & !adv1_s;

  // Saturating count of cycles where someone is waiting but S1 cannot accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule
